// File: rtl/riscv_unified_mem_ctrl_if.sv
// Request/response and memory-port bundle for riscv_unified_mem_ctrl.
// The slave modport is the controller; the master modport is the core plus memory side.
interface riscv_unified_mem_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic                if_req;
    logic [AW-1:0]       if_addr;
    logic [XLEN-1:0]     if_rdata;
    logic                if_done;
    logic                d_req;
    logic                d_we;
    logic [XLEN/8-1:0]   d_be;
    logic [AW-1:0]       d_addr;
    logic [XLEN-1:0]     d_wdata;
    logic [XLEN-1:0]     d_rdata;
    logic                d_done;
    logic                busy;
    logic                err;
    logic                mem_valid;
    logic                mem_we;
    logic [XLEN/8-1:0]   mem_be;
    logic [AW-1:0]       mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ready;
    logic [XLEN-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, busy, err,
               mem_valid, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, busy, err,
               mem_valid, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/riscv_unified_mem_ctrl.sv
// Fetch/data arbiter onto one variable-latency valid/ready memory port with bus timeout.
// Optional one-entry fetch buffer enabled by defining RISCV_IFETCH_BUF_EN.
module riscv_unified_mem_ctrl #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    riscv_unified_mem_ctrl_if.slave bus
);
    localparam int BW = XLEN / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nx;

    logic            ch_data, we_r;
    logic [BW-1:0]   be_r;
    logic [AW-1:0]   addr_r;
    logic [XLEN-1:0] wdata_r, if_rdata_r, d_rdata_r;
    logic            if_done_r, d_done_r, err_r;
    logic [CW-1:0]   cnt;
    logic            accept_d, accept_f, hit, fin_ok, fin_to;

`ifdef RISCV_IFETCH_BUF_EN
    logic            buf_valid;
    logic [AW-1:0]   buf_tag;
    logic [XLEN-1:0] buf_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // accept_f only flags fetches that actually go to memory; buffer hits stay in IDLE
    always_comb begin
        state_nx = state;
        accept_d = 1'b0;
        accept_f = 1'b0;
        hit      = 1'b0;
        fin_ok   = 1'b0;
        fin_to   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_req) begin
                    accept_d = 1'b1;
                    state_nx = ACCESS;
                end else if (bus.if_req) begin
`ifdef RISCV_IFETCH_BUF_EN
                    hit = buf_valid && (buf_tag == bus.if_addr);
`else
                    hit = 1'b0;
`endif
                    accept_f = !hit;
                    if (!hit) state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    fin_ok   = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    fin_to   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_data    <= 1'b0;
            we_r       <= 1'b0;
            be_r       <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            if_rdata_r <= '0;
            d_rdata_r  <= '0;
            if_done_r  <= 1'b0;
            d_done_r   <= 1'b0;
            err_r      <= 1'b0;
            cnt        <= '0;
`ifdef RISCV_IFETCH_BUF_EN
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_data   <= '0;
`endif
        end else begin
            if_done_r <= 1'b0;
            d_done_r  <= 1'b0;
            err_r     <= 1'b0;
            if (state == ACCESS && !bus.mem_ready) cnt <= cnt + 1'b1;
            if (accept_d) begin
                ch_data <= 1'b1;
                we_r    <= bus.d_we;
                be_r    <= bus.d_we ? bus.d_be : '1;
                addr_r  <= bus.d_addr;
                wdata_r <= bus.d_wdata;
                cnt     <= '0;
`ifdef RISCV_IFETCH_BUF_EN
                if (bus.d_we) buf_valid <= 1'b0;
`endif
            end
            if (accept_f) begin
                ch_data <= 1'b0;
                we_r    <= 1'b0;
                be_r    <= '1;
                addr_r  <= bus.if_addr;
                cnt     <= '0;
            end
`ifdef RISCV_IFETCH_BUF_EN
            if (hit) begin
                if_rdata_r <= buf_data;
                if_done_r  <= 1'b1;
            end
`endif
            // aborted reads return zero so a stale word is never mistaken for data
            if (fin_ok || fin_to) begin
                err_r <= fin_to;
                if (ch_data) begin
                    d_done_r <= 1'b1;
                    if (!we_r) d_rdata_r <= fin_ok ? bus.mem_rdata : '0;
                end else begin
                    if_done_r  <= 1'b1;
                    if_rdata_r <= fin_ok ? bus.mem_rdata : '0;
`ifdef RISCV_IFETCH_BUF_EN
                    buf_valid  <= fin_ok;
                    buf_tag    <= addr_r;
                    buf_data   <= bus.mem_rdata;
`endif
                end
`ifdef RISCV_IFETCH_BUF_EN
                if (fin_to) buf_valid <= 1'b0;
`endif
            end
        end
    end

    assign bus.mem_valid = (state == ACCESS);
    assign bus.busy      = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && we_r;
    assign bus.mem_be    = be_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_done    = d_done_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_riscv_unified_mem_ctrl.sv
// Directed self-checking bench for riscv_unified_mem_ctrl (TIMEOUT=4).
module tb_riscv_unified_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    riscv_unified_mem_ctrl_if #(.XLEN(32), .AW(32)) bus();
    riscv_unified_mem_ctrl #(.XLEN(32), .AW(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", bus.mem_valid); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_chk++; if (bus.if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata: got %h want 0", bus.if_rdata); end
        n_chk++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); end
        n_chk++; if ({bus.if_done, bus.d_done, bus.err, bus.mem_we} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {bus.if_done, bus.d_done, bus.err, bus.mem_we}); end
        n_chk++; if (bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0) begin n_fail++; $display("FAIL rst_mem_port: got addr %h be %h want 0 0", bus.mem_addr, bus.mem_be); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        tick();
        bus.if_req = 1'b0;
        n_chk++; if (bus.mem_valid !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL fetch_c1_valid: got valid %b busy %b want 1 1", bus.mem_valid, bus.busy); end
        n_chk++; if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin n_fail++; $display("FAIL fetch_port: got %h %b %h want 100 0 f", bus.mem_addr, bus.mem_we, bus.mem_be); end
        tick();
        n_chk++; if (bus.mem_valid !== 1'b1 || bus.if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_c2: got valid %b done %b want 1 0", bus.mem_valid, bus.if_done); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if (bus.if_done !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got done %b err %b want 1 0", bus.if_done, bus.err); end
        n_chk++; if (bus.if_rdata !== 32'h00500093) begin n_fail++; $display("FAIL fetch_rdata: got %h want 00500093", bus.if_rdata); end
        n_chk++; if (bus.busy !== 1'b0 || bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: got busy %b valid %b want 0 0", bus.busy, bus.mem_valid); end
        tick();
        n_chk++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_end: got %b want 0", bus.if_done); end
    endtask

    task automatic test_priority();
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        tick();
        bus.d_req = 1'b0;
        n_chk++; if (bus.mem_addr !== 32'h200 || bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL prio_first: got addr %h valid %b want 200 1", bus.mem_addr, bus.mem_valid); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11112222;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if ({bus.d_done, bus.if_done} !== 2'b10) begin n_fail++; $display("FAIL prio_done1: got d/if %b want 10", {bus.d_done, bus.if_done}); end
        n_chk++; if (bus.d_rdata !== 32'h11112222) begin n_fail++; $display("FAIL prio_d_rdata: got %h want 11112222", bus.d_rdata); end
        tick();
        bus.if_req = 1'b0;
        n_chk++; if (bus.mem_addr !== 32'h104 || bus.mem_valid !== 1'b1 || {bus.d_done, bus.if_done} !== 2'b00) begin n_fail++; $display("FAIL prio_second: got addr %h valid %b dn %b want 104 1 00", bus.mem_addr, bus.mem_valid, {bus.d_done, bus.if_done}); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h33334444;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if ({bus.d_done, bus.if_done} !== 2'b01 || bus.if_rdata !== 32'h33334444) begin n_fail++; $display("FAIL prio_done2: got d/if %b rdata %h want 01 33334444", {bus.d_done, bus.if_done}, bus.if_rdata); end
        tick();
        n_chk++; if ({bus.d_done, bus.if_done, bus.mem_valid} !== 3'b000) begin n_fail++; $display("FAIL prio_quiet: got %b want 000", {bus.d_done, bus.if_done, bus.mem_valid}); end
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h204; bus.d_wdata = 32'hDEADBEEF;
        tick();
        bus.d_req = 1'b0; bus.d_wdata = 32'h0;
        n_chk++; if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011) begin n_fail++; $display("FAIL store_we_be: got %b %b want 1 0011", bus.mem_we, bus.mem_be); end
        n_chk++; if (bus.mem_addr !== 32'h204 || bus.mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_addr_data: got %h %h want 204 deadbeef", bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hAAAAAAAA;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if (bus.d_done !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL store_done: got %b err %b want 1 0", bus.d_done, bus.err); end
        n_chk++; if (bus.d_rdata !== 32'h11112222) begin n_fail++; $display("FAIL store_rdata_kept: got %h want 11112222", bus.d_rdata); end
        tick();
        n_chk++; if (bus.d_done !== 1'b0) begin n_fail++; $display("FAIL store_pulse_end: got %b want 0", bus.d_done); end
    endtask

    task automatic test_back_to_back();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        tick();
        bus.d_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000055;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h55) begin n_fail++; $display("FAIL b2b_first: got %b %h want 1 55", bus.d_done, bus.d_rdata); end
        bus.d_req = 1'b1; bus.d_addr = 32'h304;
        tick();
        bus.d_req = 1'b0;
        n_chk++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h304) begin n_fail++; $display("FAIL b2b_accept: got %b %h want 1 304", bus.mem_valid, bus.mem_addr); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000066;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h66) begin n_fail++; $display("FAIL b2b_second: got %b %h want 1 66", bus.d_done, bus.d_rdata); end
        tick();
    endtask

    task automatic test_timeout();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h208;
        tick();
        bus.d_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_chk++; if (bus.mem_valid !== 1'b1 || bus.busy !== 1'b1 || bus.d_done !== 1'b0) begin n_fail++; $display("FAIL to_wait_c%0d: got valid %b busy %b done %b want 1 1 0", c, bus.mem_valid, bus.busy, bus.d_done); end
            tick();
        end
        n_chk++; if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL to_drop: got valid %b busy %b want 0 0", bus.mem_valid, bus.busy); end
        n_chk++; if (bus.d_done !== 1'b1 || bus.err !== 1'b1) begin n_fail++; $display("FAIL to_done_err: got %b %b want 1 1", bus.d_done, bus.err); end
        n_chk++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", bus.d_rdata); end
        tick();
        n_chk++; if (bus.err !== 1'b0 || bus.d_done !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got err %b done %b want 0 0", bus.err, bus.d_done); end
    endtask

    task automatic test_timeout_edge();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20C;
        tick();
        bus.d_req = 1'b0;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000077;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if (bus.d_done !== 1'b1 || bus.err !== 1'b0 || bus.d_rdata !== 32'h77) begin n_fail++; $display("FAIL edge_ready: got done %b err %b rdata %h want 1 0 77", bus.d_done, bus.err, bus.d_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        tick();
        bus.if_req = 1'b0;
        n_chk++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid: got %b want 1", bus.mem_valid); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got valid %b busy %b want 0 0", bus.mem_valid, bus.busy); end
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (bus.if_done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: got %b %b want 0 0", bus.if_done, bus.err); end
        bus.if_req = 1'b1; bus.if_addr = 32'h10C;
        tick();
        bus.if_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000088;
        tick();
        bus.mem_ready = 1'b0;
        n_chk++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h88) begin n_fail++; $display("FAIL rmid_after: got %b %h want 1 88", bus.if_done, bus.if_rdata); end
        tick();
    endtask

`ifdef RISCV_IFETCH_BUF_EN
    task automatic test_fetch_buf();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        tick();
        bus.if_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00A00113;
        tick();
        bus.mem_ready = 1'b0;
        bus.if_req = 1'b1;
        tick();
        bus.if_req = 1'b0;
        n_chk++; if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL buf_no_mem: got valid %b busy %b want 0 0", bus.mem_valid, bus.busy); end
        n_chk++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h00A00113) begin n_fail++; $display("FAIL buf_hit: got %b %h want 1 00a00113", bus.if_done, bus.if_rdata); end
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h400; bus.d_wdata = 32'h1;
        tick();
        bus.d_req = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        tick();
        bus.if_req = 1'b0;
        n_chk++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL buf_inval: got %b %h want 1 100", bus.mem_valid, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
    endtask
`endif

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
`ifdef RISCV_IFETCH_BUF_EN
        test_fetch_buf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
